// File: rtl/bin_timer.sv
// Programmable down-counting interval timer with one-shot/auto-reload modes,
// a one-cycle terminal-count pulse and a wrapping count of completed periods.
module bin_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             auto,
    input  logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc,
    output logic [WIDTH-1:0] laps
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] laps_q, laps_d;
    logic             tc_q, tc_d;
    logic             busy_q, busy_d;

    logic load_ok;
    logic terminal;

    // A zero period is illegal and never loads.
    assign load_ok  = start && (period != '0);
    // Terminal is detected at 1 so the count never underflows.
    assign terminal = (count_q == WIDTH'(1));

    always_comb begin
        state_d  = state_q;
        reload_d = reload_q;
        count_d  = count_q;
        laps_d   = laps_q;
        tc_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (load_ok) begin
                    reload_d = period;
                    count_d  = period;
                    laps_d   = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                if (stop) begin
                    count_d = '0;
                    state_d = S_IDLE;
                end else if (load_ok) begin
                    reload_d = period;
                    count_d  = period;
                end else if (terminal) begin
                    tc_d   = 1'b1;
                    laps_d = laps_q + WIDTH'(1);
                    if (auto) begin
                        count_d = reload_q;
                    end else begin
                        count_d = '0;
                        state_d = S_IDLE;
                    end
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
            default: begin
                count_d = '0;
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            reload_q <= '0;
            count_q  <= '0;
            laps_q   <= '0;
            tc_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            reload_q <= reload_d;
            count_q  <= count_d;
            laps_q   <= laps_d;
            tc_q     <= tc_d;
            busy_q   <= busy_d;
        end
    end

    assign count = count_q;
    assign busy  = busy_q;
    assign tc    = tc_q;
    assign laps  = laps_q;

endmodule

// File: doc/bin_timer.md
# bin_timer

Programmable down-counting interval timer that sits directly downstream of the gate/flip-flop primitive set and is the first consumer of its resettable, loadable D flip-flops in the binary-counter datapath. It loads a period, counts down one step per clock, raises a one-cycle terminal-count pulse, and either stops (one-shot) or reloads (auto mode). It also keeps a wrapping count of completed periods.

## Interface
- WIDTH, 4: width of period, count and lap counter.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; clears all state on the next clk edge.
- start  in  1  load `period` and begin or restart counting.
- stop  in  1  abort counting and return to idle.
- auto  in  1  1 = reload on terminal count; 0 = one-shot. Sampled at each terminal event.
- period  in  WIDTH  reload value, unsigned; 0 is illegal and ignored.
- count  out  WIDTH  current down-count value.
- busy  out  1  1 while in RUN.
- tc  out  1  one-cycle terminal-count pulse.
- laps  out  WIDTH  number of tc pulses since the last start from IDLE; wraps mod 2^WIDTH.

## Operation
- States: IDLE and RUN. Hold registers: `reload` (WIDTH), `count`, `laps`, `tc`, state.
- Reset values: state = IDLE, count = 0, reload = 0, laps = 0, tc = 0, busy = 0.
- IDLE:
  - start with period != 0: reload <= period, count <= period, laps <= 0, go to RUN.
  - start with period == 0: ignored and stays in IDLE. No output changes except tc, which drops to 0.
- RUN, priority from highest to lowest:
  1. stop: go to IDLE, count <= 0, tc <= 0. laps is held. A terminal event in the same cycle is suppressed.
  2. start with period != 0: retrigger. reload <= period, count <= period, tc <= 0, laps held. A terminal event in the same cycle is suppressed.
  3. Terminal (count == 1):
     - tc <= 1 and laps <= laps + 1 (wraps).
     - If auto = 1: count <= reload and stay in RUN.
     - If auto = 0: count <= 0 and go to IDLE.
  4. Otherwise: count <= count - 1 and tc <= 0.
- start with period == 0 in RUN is ignored; counting continues.
- tc is registered and is never high for two consecutive cycles, except in auto mode with reload = 1, where it is high every cycle.
- busy is the registered decode of state == RUN.
- Arithmetic: unsigned, WIDTH bits. count never underflows because the terminal event is detected at 1. The maximum period 2^WIDTH-1 is legal.

## Timing
- Edge E samples start (from IDLE, period = P). After E: count = P, busy = 1.
- After edge E+k: count = P-k, for k = 0..P-1.
- After edge E+P:
  - tc = 1.
  - one-shot: count = 0, busy = 0.
  - auto: count = P, busy = 1.
- In auto mode, tc pulses every P cycles exactly.
- Latency from start to the first tc: P cycles.
- stop latency: 1 cycle. busy = 0 and count = 0 after the sampling edge.
- reset overrides start and stop in the same cycle. Reset mid-RUN gives all outputs at reset value after the edge, with no tc.

## Test plan
- Reset then one-shot: WIDTH=4, start with P=5, auto=0 -> count 5,4,3,2,1,0. tc high only in the cycle count = 0. busy falls with it. laps = 1.
- Auto reload: P=3, auto=1, run 10 cycles -> count 3,2,1,3,2,1,3,2,1,3. tc after edges 3, 6, 9. laps = 3.
- Edge values:
  - P=1 with auto=1 -> tc high every cycle, count stays 1.
  - P=15 with auto=0 -> tc after 15 edges.
  - P=0 -> ignored, busy stays 0.
- Stop and retrigger:
  - stop coincident with count = 1 -> no tc, count = 0, laps unchanged.
  - start with P=7 while count = 2 -> count 7 next, tc suppressed.
- laps wrap: P=1, auto=1 for 17 cycles -> laps goes 15 -> 0 -> 1.
- Reset mid-run: assert reset while count = 4 with start = 1 in the same cycle -> all outputs 0, state IDLE, start ignored.
